// File: rtl/wb_gpio_pkg.sv
// Shared register map for the Wishbone GPIO block.
// The three-bit word index is decoded from wb_adr_i[2:0].
package wb_gpio_pkg;

  typedef logic [2:0] gpio_reg_idx_t;

  localparam gpio_reg_idx_t GPIO_REG_IN      = 3'd0;
  localparam gpio_reg_idx_t GPIO_REG_OUT     = 3'd1;
  localparam gpio_reg_idx_t GPIO_REG_DIR     = 3'd2;
  localparam gpio_reg_idx_t GPIO_REG_RISE_EN = 3'd3;
  localparam gpio_reg_idx_t GPIO_REG_FALL_EN = 3'd4;
  localparam gpio_reg_idx_t GPIO_REG_STATUS  = 3'd5;
  localparam gpio_reg_idx_t GPIO_REG_OUT_SET = 3'd6;
  localparam gpio_reg_idx_t GPIO_REG_OUT_CLR = 3'd7;

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone slave bundle for the GPIO block; signal names are seen from the slave side.
interface wb_gpio_irq_if #(
  parameter int unsigned WB_ADR_WIDTH = 14,
  parameter int unsigned WB_DAT_WIDTH = 16
);

  logic [WB_ADR_WIDTH-1:0] wb_adr_i;
  logic [WB_DAT_WIDTH-1:0] wb_dat_i;
  logic                    wb_we_i;
  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_ack_o;
  logic [WB_DAT_WIDTH-1:0] wb_dat_o;

  modport master (
    output wb_adr_i,
    output wb_dat_i,
    output wb_we_i,
    output wb_cyc_i,
    output wb_stb_i,
    input  wb_ack_o,
    input  wb_dat_o
  );

  modport slave (
    input  wb_adr_i,
    input  wb_dat_i,
    input  wb_we_i,
    input  wb_cyc_i,
    input  wb_stb_i,
    output wb_ack_o,
    output wb_dat_o
  );

endinterface

// File: rtl/gpio_edge_detect.sv
// Single-pin synchroniser with a one-cycle history flop for edge detection.
module gpio_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO port: per-pin direction, atomic set/clear, synchronised inputs and
// rising/falling edge interrupts collected in a write-1-to-clear status register.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int unsigned           GPIO_WIDTH    = 16,
  parameter int unsigned           WB_DAT_WIDTH  = 16,
  parameter int unsigned           WB_ADR_WIDTH  = 14,
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET_VAL = '0,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_gpio_irq_if.slave          wb,
  inout  wire  [GPIO_WIDTH-1:0] gpio_io,
  output logic                  irq_o
);

  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned ARM_CNT_W  = $clog2(ARM_CYCLES + 1);

  logic [GPIO_WIDTH-1:0]   r_out;
  logic [GPIO_WIDTH-1:0]   r_dir;
  logic [GPIO_WIDTH-1:0]   r_rise_en;
  logic [GPIO_WIDTH-1:0]   r_fall_en;
  logic [GPIO_WIDTH-1:0]   r_status;
  logic                    r_ack;
  logic [WB_DAT_WIDTH-1:0] r_dat_o;
  logic                    r_irq;
  logic [ARM_CNT_W-1:0]    r_arm_cnt;

  logic                    w_sel;
  logic                    w_accept;
  logic                    w_wr;
  gpio_reg_idx_t           w_idx;
  logic [GPIO_WIDTH-1:0]   w_wdata;
  logic [GPIO_WIDTH-1:0]   w_sync;
  logic [GPIO_WIDTH-1:0]   w_rise;
  logic [GPIO_WIDTH-1:0]   w_fall;
  logic [GPIO_WIDTH-1:0]   w_ev;
  logic [GPIO_WIDTH-1:0]   w_w1c;
  logic                    w_armed;
  logic [GPIO_WIDTH-1:0]   w_rd_gpio;
  logic [WB_DAT_WIDTH-1:0] w_rd_data;

  // Bus decode; r_ack blocks a second accept so every access has one wait state.
  assign w_sel    = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_accept = w_sel & ~r_ack;
  assign w_wr     = w_accept & wb.wb_we_i;
  assign w_idx    = wb.wb_adr_i[2:0];
  assign w_wdata  = wb.wb_dat_i[GPIO_WIDTH-1:0];

  if (WB_ADR_WIDTH > 3) begin : g_adr_unused
    logic w_unused_adr;
    assign w_unused_adr = ^wb.wb_adr_i[WB_ADR_WIDTH-1:3];
  end

  if (WB_DAT_WIDTH > GPIO_WIDTH) begin : g_dat_unused
    logic w_unused_dat;
    assign w_unused_dat = ^wb.wb_dat_i[WB_DAT_WIDTH-1:GPIO_WIDTH];
  end

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pin
    gpio_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_pin  (gpio_io[g]),
      .o_sync (w_sync[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );

    assign gpio_io[g] = r_dir[g] ? r_out[g] : 1'bz;
  end

  // Edges seen before the synchroniser has flushed its reset zeros are ignored.
  assign w_armed = (r_arm_cnt == ARM_CNT_W'(ARM_CYCLES));
  assign w_ev    = w_armed ? (~r_dir & ((w_rise & r_rise_en) | (w_fall & r_fall_en)))
                           : '0;
  assign w_w1c   = (w_wr && (w_idx == GPIO_REG_STATUS)) ? w_wdata : '0;

  always_comb begin
    w_rd_gpio = '0;
    case (w_idx)
      GPIO_REG_IN:      w_rd_gpio = w_sync;
      GPIO_REG_OUT:     w_rd_gpio = r_out;
      GPIO_REG_DIR:     w_rd_gpio = r_dir;
      GPIO_REG_RISE_EN: w_rd_gpio = r_rise_en;
      GPIO_REG_FALL_EN: w_rd_gpio = r_fall_en;
      GPIO_REG_STATUS:  w_rd_gpio = r_status;
      default:          w_rd_gpio = '0;
    endcase
    w_rd_data                 = '0;
    w_rd_data[GPIO_WIDTH-1:0] = w_rd_gpio;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept && !wb.wb_we_i) begin
        r_dat_o <= w_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= OUT_RESET_VAL;
      r_dir     <= DIR_RESET_VAL;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (w_idx)
        GPIO_REG_OUT:     r_out     <= w_wdata;
        GPIO_REG_DIR:     r_dir     <= w_wdata;
        GPIO_REG_RISE_EN: r_rise_en <= w_wdata;
        GPIO_REG_FALL_EN: r_fall_en <= w_wdata;
        GPIO_REG_OUT_SET: r_out     <= r_out | w_wdata;
        GPIO_REG_OUT_CLR: r_out     <= r_out & ~w_wdata;
        default: ;
      endcase
    end
  end

  // New events are OR-ed in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status  <= '0;
      r_irq     <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_status <= (r_status & ~w_w1c) | w_ev;
      r_irq    <= |r_status;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 1'b1;
      end
    end
  end

  assign wb.wb_ack_o = w_sel & r_ack;
  assign wb.wb_dat_o = r_dat_o;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed and randomized bench for wb_gpio_irq against a pin-level behavioural model.
module tb_wb_gpio_irq;

  localparam int unsigned GW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 14;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_gpio_irq_if #(.WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW)) bus ();

  wire  [GW-1:0] pads;
  logic          irq;

  // Model state; pins are driven by the bench wherever the model says input.
  logic [GW-1:0] drv;
  logic [GW-1:0] m_out, m_dir, m_rise, m_fall, m_status;

  for (genvar i = 0; i < GW; i++) begin : g_pad
    assign pads[i] = m_dir[i] ? 1'bz : drv[i];
  end

  wb_gpio_irq #(
    .GPIO_WIDTH   (GW),
    .WB_DAT_WIDTH (DW),
    .WB_ADR_WIDTH (AW),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb      (bus),
    .gpio_io (pads),
    .irq_o   (irq)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            lat;
  logic          irq_at_ack;
  logic [DW-1:0] rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] levels();
    return (m_dir & m_out) | (~m_dir & drv);
  endfunction

  // A level change on an input pin raises its flag if the matching edge is enabled.
  task automatic apply_edges(input logic [GW-1:0] old_l, input logic [GW-1:0] new_l);
    for (int i = 0; i < GW; i++) begin
      if (!m_dir[i] && (old_l[i] != new_l[i])) begin
        if ((new_l[i] && m_rise[i]) || (!new_l[i] && m_fall[i])) m_status[i] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
  endtask

  task automatic model_write(input logic [2:0] adr, input logic [GW-1:0] d);
    case (adr)
      3'd1: m_out = d;
      3'd2: m_dir = d;
      3'd3: m_rise = d;
      3'd4: m_fall = d;
      3'd5: m_status = m_status & ~d;
      3'd6: m_out = m_out | d;
      3'd7: m_out = m_out & ~d;
      default: ;
    endcase
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [2:0] adr);
    case (adr)
      3'd0: return levels();
      3'd1: return m_out;
      3'd2: return m_dir;
      3'd3: return m_rise;
      3'd4: return m_fall;
      3'd5: return m_status;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (SS + 3) tick();
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
  endtask

  // One access; the model is updated at the ack sample, before the next edge.
  task automatic wb_access(input logic we, input logic [2:0] adr, input logic [DW-1:0] wdata,
                           output logic [DW-1:0] rd);
    logic [GW-1:0] old_l;
    bus.wb_adr_i      = AW'($urandom);
    bus.wb_adr_i[2:0] = adr;
    bus.wb_dat_i      = wdata;
    bus.wb_we_i       = we;
    bus.wb_cyc_i      = 1'b1;
    bus.wb_stb_i      = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.wb_ack_o && lat < 8);
    check("ack_latency", 32'(lat), 32'd1);
    rd         = bus.wb_dat_o;
    irq_at_ack = irq;
    if (we) begin
      old_l = levels();
      model_write(adr, wdata);
      apply_edges(old_l, levels());
    end
    bus_idle();
    tick();
  endtask

  task automatic wr(input logic [2:0] adr, input logic [DW-1:0] d);
    logic [DW-1:0] unused_rd;
    wb_access(1'b1, adr, d, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] adr);
    logic [DW-1:0] e;
    e = exp_rd(adr);
    wb_access(1'b0, adr, '0, rdata);
    check(tag, 32'(rdata), 32'(e));
  endtask

  task automatic set_drv(input logic [GW-1:0] v);
    logic [GW-1:0] old_l;
    old_l = levels();
    drv   = v;
    apply_edges(old_l, levels());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]    a;
    logic [DW-1:0] d;
    bus_idle();
    drv = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    settle();

    // Reset values of every register
    for (int r = 0; r < 8; r++) rd_chk("reset_reg", 3'(r));
    check("reset_irq", 32'(irq), 32'd0);

    // Direction, output and atomic set/clear
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00A5);
    wr(3'd6, 16'h0100);
    wr(3'd7, 16'h0005);
    set_drv(GW'($urandom) & 16'hFF00);
    settle();
    rd_chk("out_after_setclr", 3'd1);
    check("out_const", 32'(rdata), 32'h01A0);
    check("pads_low", 32'(pads[7:0]), 32'hA0);
    rd_chk("in_mixed", 3'd0);
    rd_chk("out_set_reads0", 3'd6);

    // Rising edge on pin 15: status and irq timing, then W1C
    wr(3'd3, 16'h8000);
    set_drv(drv & 16'h7FFF);
    settle();
    wr(3'd5, 16'hFFFF);
    settle();
    set_drv(drv | 16'h8000);
    tick();
    tick();
    check("irq_early", 32'(irq), 32'd0);
    wb_access(1'b0, 3'd5, '0, rdata);
    check("status_not_yet", 32'(rdata), 32'h0);
    check("irq_at_status_edge", 32'(irq_at_ack), 32'd0);
    check("irq_one_after", 32'(irq), 32'd1);
    rd_chk("status_rise15", 3'd5);
    wr(3'd5, 16'h8000);
    check("irq_hold_after_w1c", 32'(irq_at_ack), 32'd1);
    check("irq_drop", 32'(irq), 32'd0);
    rd_chk("status_cleared", 3'd5);

    // Output-direction pin never raises an event
    wr(3'd4, 16'h0100);
    wr(3'd2, m_dir | 16'h0100);
    wr(3'd6, 16'h0100);
    settle();
    wr(3'd7, 16'h0100);
    settle();
    wr(3'd6, 16'h0100);
    settle();
    rd_chk("status_out_pin", 3'd5);
    set_drv(drv | 16'h0100);
    wr(3'd2, m_dir & ~16'h0100);
    settle();
    set_drv(drv & ~16'h0100);
    settle();
    rd_chk("status_fall8", 3'd5);
    check("status_bit8", 32'(rdata[8]), 32'd1);

    // Event and W1C on the same edge: the event wins
    wr(3'd2, m_dir & ~16'h0008);
    wr(3'd3, m_rise | 16'h0008);
    wr(3'd4, m_fall | 16'h0008);
    settle();
    wr(3'd5, 16'hFFFF);
    set_drv(drv | 16'h0008);
    settle();
    rd_chk("status_bit3_set", 3'd5);
    set_drv(drv & ~16'h0008);
    tick();
    tick();
    wr(3'd5, 16'h0008);
    m_status[3] = 1'b1;
    settle();
    rd_chk("status_w1c_race", 3'd5);
    check("status_bit3_kept", 32'(rdata[3]), 32'd1);

    // Pins high through reset produce no rising events
    rst_n = 1'b0;
    model_reset();
    drv = 16'hFFFF;
    repeat (3) tick();
    rst_n = 1'b1;
    wr(3'd3, 16'hFFFF);
    settle();
    rd_chk("status_after_reset_high", 3'd5);
    check("irq_after_reset_high", 32'(irq), 32'd0);
    set_drv(16'h0F0F);
    settle();
    set_drv(16'hFFFF);
    settle();
    rd_chk("status_post_arm", 3'd5);
    check("irq_post_arm", 32'(irq), 32'(|m_status));

    // Reset during an access: no ack ever delivered
    bus.wb_adr_i = '0; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ack_in_reset", 32'(bus.wb_ack_o), 32'd0);
    end
    bus_idle();
    rst_n = 1'b1;
    settle();
    bus.wb_adr_i = '0; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ack_cut_by_reset", 32'(bus.wb_ack_o), 32'd0);
    check("dat_cut_by_reset", 32'(bus.wb_dat_o), 32'd0);
    bus_idle();
    tick();
    rst_n = 1'b1;
    settle();

    // Randomized register traffic and pin activity
    for (int it = 0; it < 80; it++) begin
      d = DW'($urandom);
      case ($urandom_range(0, 8))
        0: wr(3'd1, d);
        1: wr(3'd2, d);
        2: wr(3'd3, d);
        3: wr(3'd4, d);
        4: wr(3'd5, d);
        5: wr(3'd6, d);
        6: wr(3'd7, d);
        7: set_drv(d);
        default: wr(3'd0, d);
      endcase
      settle();
      a = 3'($urandom_range(0, 7));
      rd_chk("rand_read", a);
      check("rand_irq", 32'(irq), 32'(|m_status));
      check("rand_pads", 32'(pads & m_dir), 32'(m_out & m_dir));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
